mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one fixed-latency, single-ported memory between instruction fetch (IF) and data access (MEM stage).
//  Keeps at most one access in flight and returns read data with a one-cycle ready pulse.
//  Raises stall_if / stall_mem toward the hazard logic, which holds PCWrite / IF2ID_write low or freezes the pipe.
// PARAMETERS
//  ADDR_W      32  address width, byte address
//  DATA_W      32  data width
//  MEM_LAT     2   cycles from mem_en to valid mem_rdata; legal range 1..15
//  STARVE_MAX  4   consecutive data grants allowed while if_req waits; legal range 1..15
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous reset, active-high
//  if_req     in   1       instruction fetch request; held with if_addr until if_ready
//  if_addr    in   ADDR_W  fetch address
//  if_rdata   out  DATA_W  fetched word; valid only while if_ready=1
//  if_ready   out  1       one-cycle completion pulse for IF
//  dm_req     in   1       data request; held with dm_we/addr/wdata until dm_ready
//  dm_we      in   1       1=store, 0=load
//  dm_addr    in   ADDR_W  data address
//  dm_wdata   in   DATA_W  store data
//  dm_rdata   out  DATA_W  load data; valid only while dm_ready=1
//  dm_ready   out  1       one-cycle completion pulse for MEM
//  mem_en     out  1       one-cycle issue strobe to memory (registered)
//  mem_we     out  1       write enable, qualified by mem_en (registered)
//  mem_addr   out  ADDR_W  registered issue address
//  mem_wdata  out  DATA_W  registered store data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
//  stall_if   out  1       if_req & ~if_ready (combinational)
//  stall_mem  out  1       dm_req & ~dm_ready (combinational)
// BEHAVIOUR
//  - Reset values: state IDLE, mem_en/mem_we/if_ready/dm_ready = 0, mem_addr/mem_wdata/rdata = 0, starve_cnt = 0, lat_cnt = 0.
//  - States: IDLE, ISSUE, WAIT, DONE. The owner register (IF or DM) is captured at grant.
//  - IDLE: when any request is pending, grant and go to ISSUE. The next cycle drives mem_en=1 plus the latched addr/we/wdata.
//  - Priority: DM wins over IF (older instruction first). Exception: starve_cnt==STARVE_MAX with if_req=1 grants IF.
//  - starve_cnt: +1 on each DM grant while if_req=1; cleared on IF grant or when if_req=0 at grant; saturates.
//  - ISSUE: mem_en=1 for exactly one cycle, lat_cnt=MEM_LAT-1, go to WAIT.
//  - WAIT: decrement lat_cnt; at 0 go to DONE.
//  - DONE: capture mem_rdata into the owner's rdata register. Pulse the owner's ready for 1 cycle, then IDLE.
//  - Latency: request seen in IDLE at cycle t gives mem_en at t+1 and ready at t+2+MEM_LAT.
//  - Throughput: one access per MEM_LAT+3 cycles. No grant while ready is high (DONE to IDLE first).
//  - Stores: ready pulses on the same schedule; rdata is unchanged (holds the last load value).
//  - Requests arriving mid-access wait. Both requests in the same IDLE cycle resolve by the priority rule.
//  - Request dropped mid-access (IF flushed by jump/branch): the access still completes and ready still pulses.
//    The requester ignores it. No abort path exists.
//  - stall_if/stall_mem are 0 in the ready cycle, so the pipeline advances exactly on completion.
//  - Reset asserted mid-access: immediate return to IDLE. The outstanding access is dropped and no ready pulse is produced.
//    mem_en=0 from reset assertion.
//  - Only one of if_ready/dm_ready is ever high; mem_en is never high in two consecutive cycles.
// TESTING (MEM_LAT=2, STARVE_MAX=4 unless noted)
//  1. Single IF read: if_req=1 with if_addr=0x0040_0000 at cycle 1. Required: mem_en at cycle 2 with that addr;
//     memory returns 0x2008_0005 at cycle 4; if_ready=1 with if_rdata=0x2008_0005 at cycle 5; stall_if=1 in cycles 1-4.
//  2. Simultaneous requests: if_req and dm_req (load 0x1000_0010) together in IDLE. Required: DM issued first, dm_ready at +4;
//     IF issued next, if_ready 5 cycles after dm_ready... i.e. next grant in IDLE at dm_ready+1, ready 4 cycles after that grant.
//  3. Starvation: dm_req held high for 6 accesses while if_req=1. Required: grants DM,DM,DM,DM,IF,DM,DM; starve_cnt returns to 0 after the IF grant.
//  4. Store: dm_we=1, dm_addr=0x1000_0000, dm_wdata=0xDEAD_BEEF. Required: mem_we=1 and mem_wdata=0xDEAD_BEEF on the mem_en cycle;
//     dm_ready pulses; dm_rdata is unchanged.
//  5. Flush mid-fetch: if_req dropped in WAIT. Required: if_ready still pulses once, state returns to IDLE, no extra mem_en.
//  6. Reset in WAIT (MEM_LAT=4): reset asserted asynchronously. Required: no ready pulse, all outputs 0 immediately;
//     a request after reset release is served normally with the cycle-1 timing of test 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-ported memory arbiter between instruction fetch and data access
//
// Purpose:
//   Shares one fixed-latency, single-ported memory between the IF stage and the
//   MEM stage. At most one access is in flight. Each access walks
//   IDLE -> ISSUE -> WAIT -> DONE, so an access granted in cycle t strobes
//   mem_en in t+1 and pulses the owner's ready in t+2+MEM_LAT. Data access
//   wins ties unless the fetch side has already been passed over STARVE_MAX
//   times in a row.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   if_req/if_addr                  fetch request, held until if_ready
//   if_rdata/if_ready               fetched word and its one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata   data request, held until dm_ready
//   dm_rdata/dm_ready               load data and its one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata registered issue interface to the memory
//   mem_rdata                       memory read data, valid MEM_LAT cycles after mem_en
//   stall_if/stall_mem              combinational stall requests to the hazard logic

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic [3:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       owner_if;   // 1: current access belongs to IF, 0: to DM
    logic       owner_we;   // current access is a store

    logic       grant;
    logic       grant_if;
    logic       starve_hit;
    logic       data_valid;

    assign starve_hit = (starve_cnt == 4'(STARVE_MAX));

    // mem_rdata is valid in the last WAIT cycle; it is captured on the edge
    // into DONE so the ready pulse and the rdata register line up in DONE.
    assign data_valid = (state_q == S_WAIT) && (lat_cnt == 4'd0);

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        grant_if = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    grant    = 1'b1;
                    // Older instruction (DM) first, unless fetch has starved.
                    grant_if = if_req && (!dm_req || starve_hit);
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (lat_cnt == 4'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lat_cnt    <= 4'd0;
            starve_cnt <= 4'd0;
            owner_if   <= 1'b0;
            owner_we   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            state_q <= state_d;

            // Issue strobe lasts exactly the ISSUE cycle.
            mem_en <= grant;
            mem_we <= grant && !grant_if && dm_we;

            if (grant) begin
                owner_if <= grant_if;
                owner_we <= !grant_if && dm_we;
                if (grant_if) begin
                    mem_addr   <= if_addr;
                    starve_cnt <= 4'd0;
                end else begin
                    mem_addr  <= dm_addr;
                    mem_wdata <= dm_wdata;
                    if (!if_req) begin
                        starve_cnt <= 4'd0;
                    end else if (!starve_hit) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end
            end

            if (state_q == S_ISSUE) begin
                lat_cnt <= 4'(MEM_LAT - 1);
            end else if (state_q == S_WAIT && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            if_ready <= data_valid && owner_if;
            dm_ready <= data_valid && !owner_if;

            // Stores leave dm_rdata holding the last load value.
            if (data_valid) begin
                if (owner_if) begin
                    if_rdata <= mem_rdata;
                end else if (!owner_we) begin
                    dm_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
